pattern_sig_checker: RTL and testbench
======================================

Name:
pattern_sig_checker

Overview:
- Sequential equivalence-screening engine for two combinational netlist variants (golden and revised) that share a common input vector.
- An LFSR generates a configurable number of pseudo-random input patterns and drives both netlists.
- Each cycle the engine compares the two response vectors, compacts each into its own MISR signature, and records the first mismatching pattern.
- Parametrised successor of fixed-width flat netlists: width, polynomial, response latency and abort mode are all configurable.

Parameters:
- IN_W, 14: pattern width; LFSR width. Minimum 2.
- OUT_W, 8: response width; MISR width. Minimum 2.
- CNT_W, 16: pattern counter width. Maximum run length is 2^CNT_W-1 patterns.
- POLY, 14'h0403: Galois LFSR feedback mask, IN_W bits.
- SEED, 14'h0001: LFSR load value. A value of 0 is replaced by 1.
- MPOLY, 8'h1D: MISR feedback mask, OUT_W bits.
- LAT, 0: response latency in cycles, from pat_out to a valid golden_in/revised_in. Range 0..7.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- num_pat  in  CNT_W  number of patterns; captured on start.
- stop_on_fail  in  1  abort after the first mismatch; captured on start.
- pat_out  out  IN_W  pattern driven to both netlists.
- golden_in  in  OUT_W  golden netlist response.
- revised_in  in  OUT_W  revised netlist response.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at end of run.
- mismatch  out  1  sticky; set if any compared response differed.
- fail_idx  out  CNT_W  index (0-based) of the first mismatching pattern.
- fail_vec  out  OUT_W  golden_in XOR revised_in at the first mismatch.
- sig_golden  out  OUT_W  golden MISR signature.
- sig_revised  out  OUT_W  revised MISR signature.

Behaviour:
- Reset: every output and all internal state go to 0; FSM goes to IDLE. Reset takes effect immediately, including mid-run. No done pulse is generated on reset.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE with start=1 and num_pat!=0:
  - Capture num_pat and stop_on_fail.
  - Clear mismatch, fail_idx, fail_vec and both MISRs.
  - Load the LFSR with SEED; pat_out=SEED on the next cycle; go to RUN.
- IDLE with start=1 and num_pat=0: go to DONE; status is cleared and no pattern is issued.
- start outside IDLE is ignored.
- LFSR step, once per RUN cycle: next = {s[IN_W-2:0],0} ^ (s[IN_W-1] ? POLY : 0). pat_out is registered and holds pattern k for exactly one cycle, for k = 0..num_pat-1.
- RUN exit: after the cycle presenting pattern num_pat-1, go to DRAIN. pat_out holds its last value after RUN.
- Response valid: a delay line of depth LAT carries a valid flag and the pattern index. With LAT=0, responses are sampled in the same cycle the pattern is presented.
- On each valid response:
  - Each MISR updates as m_next = {m[OUT_W-2:0],0} ^ (m[OUT_W-1] ? MPOLY : 0) ^ resp.
  - If golden_in != revised_in and mismatch=0: set mismatch; capture fail_idx = delayed index and fail_vec = XOR of the two responses.
  - Later mismatches leave fail_idx and fail_vec unchanged.
- DRAIN: waits until the delay line is empty (LAT cycles), then goes to DONE. With LAT=0, DRAIN lasts 1 cycle and samples nothing.
- stop_on_fail=1: on the first mismatch, stop issuing patterns and go to DRAIN.
  - Responses still in flight update the MISRs.
  - The pattern counter freezes.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
- Result hold: mismatch, fail_idx, fail_vec and the signatures hold until the next accepted start.
- Pattern count wrap: the counter never wraps because num_pat < 2^CNT_W. The LFSR may wrap through its period without any special handling.

Test Plan:
- Instance IN_W=4, OUT_W=4, POLY=4'h3, SEED=1, LAT=0, with golden_in=revised_in=pat_out. Apply num_pat=5 -> pat_out 1,2,4,8,3 on consecutive cycles; done 1 cycle after pattern 3 plus DRAIN; mismatch=0; sig_golden=sig_revised.
- Same instance, revised_in = golden_in ^ 4'h1 only when pat_out=8 -> mismatch=1, fail_idx=3, fail_vec=4'h1; run completes all 5 patterns; sig_golden != sig_revised.
- Same injection plus a second injection at pat_out=3, stop_on_fail=1 -> no pattern after 8 is issued; fail_idx=3 unchanged; done asserted.
- num_pat=0 -> done pulse 2 cycles after start; busy stays 0; pat_out unchanged; status all 0.
- LAT=2 instance, responses delayed by 2 flops, num_pat=15 -> full LFSR period 1..9, then DRAIN for 2 cycles; mismatch=0; start pulses during busy are ignored.
- Assert rst during RUN at pattern 2 -> all outputs 0 immediately; no done pulse; a new start restarts from SEED.

Source files
------------

// File: rtl/pattern_sig_checker.sv
// pattern_sig_checker: LFSR-driven equivalence screen for two netlist
// variants. Ports: clk, rst (async, active high), start, num_pat,
// stop_on_fail, pat_out, golden_in, revised_in, busy, done, mismatch,
// fail_idx, fail_vec, sig_golden, sig_revised.
module pattern_sig_checker #(
    parameter int               IN_W  = 14,
    parameter int               OUT_W = 8,
    parameter int               CNT_W = 16,
    parameter logic [IN_W-1:0]  POLY  = 14'h0403,
    parameter logic [IN_W-1:0]  SEED  = 14'h0001,
    parameter logic [OUT_W-1:0] MPOLY = 8'h1D,
    parameter int               LAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pat,
    input  logic             stop_on_fail,
    output logic [IN_W-1:0]  pat_out,
    input  logic [OUT_W-1:0] golden_in,
    input  logic [OUT_W-1:0] revised_in,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] fail_idx,
    output logic [OUT_W-1:0] fail_vec,
    output logic [OUT_W-1:0] sig_golden,
    output logic [OUT_W-1:0] sig_revised
);

    // An all-zero seed would lock the LFSR at zero.
    localparam logic [IN_W-1:0] SEED_L =
        (SEED == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : SEED;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [IN_W-1:0]  r_pat;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_num;
    logic             r_stop;
    logic             r_mis;
    logic [CNT_W-1:0] r_fidx;
    logic [OUT_W-1:0] r_fvec;
    logic [OUT_W-1:0] r_sig_g;
    logic [OUT_W-1:0] r_sig_r;

    logic             w_accept;
    logic             w_v0;
    logic             w_rv;
    logic [CNT_W-1:0] w_ridx;
    logic             w_pipe_busy;
    logic             w_last;
    logic             w_fail_now;
    logic             w_stop_now;
    logic             w_leave_run;
    logic [IN_W-1:0]  w_lfsr_nx;

    function automatic logic [OUT_W-1:0] misr_step(
        input logic [OUT_W-1:0] m,
        input logic [OUT_W-1:0] r
    );
        return {m[OUT_W-2:0], 1'b0} ^ (m[OUT_W-1] ? MPOLY : '0) ^ r;
    endfunction

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_v0        = (r_state == S_RUN);
    assign w_last      = (r_cnt == r_num - CNT_W'(1));
    assign w_fail_now  = w_rv && (golden_in != revised_in) && !r_mis;
    assign w_stop_now  = r_stop && w_fail_now;
    assign w_leave_run = w_last || w_stop_now;
    assign w_lfsr_nx   = {r_pat[IN_W-2:0], 1'b0}
                       ^ (r_pat[IN_W-1] ? POLY : '0);

    // Valid flag and pattern index travel alongside the netlist latency.
    generate
        if (LAT == 0) begin : g_nodly
            assign w_rv        = w_v0;
            assign w_ridx      = r_cnt;
            assign w_pipe_busy = 1'b0;
        end else begin : g_dly
            logic [LAT-1:0]   r_dv;
            logic [CNT_W-1:0] r_didx [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dv <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        r_didx[i] <= '0;
                    end
                end else begin
                    r_dv[0]   <= w_v0;
                    r_didx[0] <= r_cnt;
                    for (int i = 1; i < LAT; i++) begin
                        r_dv[i]   <= r_dv[i-1];
                        r_didx[i] <= r_didx[i-1];
                    end
                end
            end

            assign w_rv   = r_dv[LAT-1];
            assign w_ridx = r_didx[LAT-1];

            // Anything still short of the last stage needs another cycle.
            always_comb begin
                w_pipe_busy = 1'b0;
                for (int i = 0; i < LAT - 1; i++) begin
                    w_pipe_busy = w_pipe_busy | r_dv[i];
                end
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = (num_pat != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_leave_run) begin
                    w_state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_pipe_busy) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Pattern generator, signatures and first-fail capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat   <= '0;
            r_cnt   <= '0;
            r_num   <= '0;
            r_stop  <= 1'b0;
            r_mis   <= 1'b0;
            r_fidx  <= '0;
            r_fvec  <= '0;
            r_sig_g <= '0;
            r_sig_r <= '0;
        end else if (w_accept) begin
            r_num   <= num_pat;
            r_stop  <= stop_on_fail;
            r_mis   <= 1'b0;
            r_fidx  <= '0;
            r_fvec  <= '0;
            r_sig_g <= '0;
            r_sig_r <= '0;
            // A zero-length run leaves the last pattern on the bus.
            if (num_pat != '0) begin
                r_pat <= SEED_L;
                r_cnt <= '0;
            end
        end else begin
            if ((r_state == S_RUN) && !w_leave_run) begin
                r_pat <= w_lfsr_nx;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_rv) begin
                r_sig_g <= misr_step(r_sig_g, golden_in);
                r_sig_r <= misr_step(r_sig_r, revised_in);
            end
            if (w_fail_now) begin
                r_mis  <= 1'b1;
                r_fidx <= w_ridx;
                r_fvec <= golden_in ^ revised_in;
            end
        end
    end

    assign pat_out     = r_pat;
    assign mismatch    = r_mis;
    assign fail_idx    = r_fidx;
    assign fail_vec    = r_fvec;
    assign sig_golden  = r_sig_g;
    assign sig_revised = r_sig_r;

endmodule

// File: tb/tb_pattern_sig_checker.sv
// tb_pattern_sig_checker: directed bench for two instances
// (LAT=0 with fault injection, LAT=2 with a 2-flop response path).
module tb_pattern_sig_checker;

    localparam logic [3:0] SEQ [15] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
        4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
    };

    int n_pass = 0;
    int n_total = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start0 = 1'b0;
    logic        sof0 = 1'b0;
    logic [15:0] num0 = '0;
    logic [3:0]  pat0, gold0, rev0, fvec0, sg0, sr0;
    logic        busy0, done0, mis0;
    logic [15:0] fidx0;
    logic        inj8 = 1'b0;
    logic        inj3 = 1'b0;

    logic        start2 = 1'b0;
    logic [15:0] num2 = '0;
    logic [3:0]  pat2, fvec2, sg2, sr2;
    logic        busy2, done2, mis2;
    logic [15:0] fidx2;
    logic [3:0]  d1 = '0;
    logic [3:0]  d2 = '0;

    always #5 clk = ~clk;

    assign gold0 = pat0;
    assign rev0  = pat0 ^ {3'b000,
                   (inj8 && pat0 == 4'h8) || (inj3 && pat0 == 4'h3)};

    always @(posedge clk) begin
        d1 <= pat2;
        d2 <= d1;
    end

    pattern_sig_checker #(
        .IN_W(4), .OUT_W(4), .CNT_W(16), .POLY(4'h3),
        .SEED(4'h1), .MPOLY(4'h3), .LAT(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .num_pat(num0),
        .stop_on_fail(sof0), .pat_out(pat0), .golden_in(gold0),
        .revised_in(rev0), .busy(busy0), .done(done0),
        .mismatch(mis0), .fail_idx(fidx0), .fail_vec(fvec0),
        .sig_golden(sg0), .sig_revised(sr0)
    );

    pattern_sig_checker #(
        .IN_W(4), .OUT_W(4), .CNT_W(16), .POLY(4'h3),
        .SEED(4'h1), .MPOLY(4'h3), .LAT(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .num_pat(num2),
        .stop_on_fail(1'b0), .pat_out(pat2), .golden_in(d2),
        .revised_in(d2), .busy(busy2), .done(done2),
        .mismatch(mis2), .fail_idx(fidx2), .fail_vec(fvec2),
        .sig_golden(sg2), .sig_revised(sr2)
    );

    task automatic test_reset;
        #2;
        n_total++;
        if (pat0 !== 4'h0) $display("FAIL rst_pat0 got %h want 0", pat0);
        else n_pass++;
        n_total++;
        if ({busy0, done0, mis0} !== 3'b000)
            $display("FAIL rst_flags0 got %b want 000", {busy0, done0, mis0});
        else n_pass++;
        n_total++;
        if ({fidx0, fvec0, sg0, sr0} !== 28'h0)
            $display("FAIL rst_status0 got %h want 0",
                     {fidx0, fvec0, sg0, sr0});
        else n_pass++;
        n_total++;
        if ({pat2, busy2, done2, sg2} !== 10'h0)
            $display("FAIL rst_dut2 got %h want 0", {pat2, busy2, done2, sg2});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clean_run;
        @(negedge clk);
        start0 = 1'b1; num0 = 16'd5; sof0 = 1'b0;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_total++;
            if (pat0 !== SEQ[i] || busy0 !== 1'b1)
                $display("FAIL clean_pat%0d got %h/%b want %h/1",
                         i, pat0, busy0, SEQ[i]);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if (busy0 !== 1'b1 || done0 !== 1'b0 || pat0 !== 4'h3)
            $display("FAIL clean_drain got b%b d%b p%h want b1 d0 p3",
                     busy0, done0, pat0);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done0 !== 1'b1 || busy0 !== 1'b0)
            $display("FAIL clean_done got d%b b%b want d1 b0", done0, busy0);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done0 !== 1'b0)
            $display("FAIL clean_done_pulse got %b want 0", done0);
        else n_pass++;
        n_total++;
        if (mis0 !== 1'b0 || sg0 !== 4'h3 || sr0 !== 4'h3)
            $display("FAIL clean_sig got m%b g%h r%h want m0 g3 r3",
                     mis0, sg0, sr0);
        else n_pass++;
    endtask

    task automatic test_inject;
        inj8 = 1'b1;
        @(negedge clk);
        start0 = 1'b1; num0 = 16'd5; sof0 = 1'b0;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_total++;
            if (pat0 !== SEQ[i])
                $display("FAIL inj_pat%0d got %h want %h", i, pat0, SEQ[i]);
            else n_pass++;
        end
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (done0 !== 1'b1)
            $display("FAIL inj_done got %b want 1", done0);
        else n_pass++;
        n_total++;
        if (mis0 !== 1'b1 || fidx0 !== 16'd3 || fvec0 !== 4'h1)
            $display("FAIL inj_capture got m%b i%0d v%h want m1 i3 v1",
                     mis0, fidx0, fvec0);
        else n_pass++;
        n_total++;
        if (sg0 !== 4'h3 || sr0 !== 4'h1)
            $display("FAIL inj_sig got g%h r%h want g3 r1", sg0, sr0);
        else n_pass++;
        inj8 = 1'b0;
    endtask

    task automatic test_stop_on_fail;
        inj8 = 1'b1; inj3 = 1'b1;
        @(negedge clk);
        start0 = 1'b1; num0 = 16'd5; sof0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; sof0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_total++;
            if (pat0 !== SEQ[i])
                $display("FAIL sof_pat%0d got %h want %h", i, pat0, SEQ[i]);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if (pat0 !== 4'h8 || busy0 !== 1'b1 || done0 !== 1'b0)
            $display("FAIL sof_drain got p%h b%b d%b want p8 b1 d0",
                     pat0, busy0, done0);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done0 !== 1'b1 || pat0 !== 4'h8)
            $display("FAIL sof_done got d%b p%h want d1 p8", done0, pat0);
        else n_pass++;
        n_total++;
        if (mis0 !== 1'b1 || fidx0 !== 16'd3 || fvec0 !== 4'h1)
            $display("FAIL sof_capture got m%b i%0d v%h want m1 i3 v1",
                     mis0, fidx0, fvec0);
        else n_pass++;
        n_total++;
        if (sg0 !== 4'h0 || sr0 !== 4'h1)
            $display("FAIL sof_sig got g%h r%h want g0 r1", sg0, sr0);
        else n_pass++;
        inj8 = 1'b0; inj3 = 1'b0;
    endtask

    task automatic test_zero_count;
        int n_done;
        int first_done;
        int n_busy;
        n_done = 0; first_done = 0; n_busy = 0;
        @(negedge clk);
        start0 = 1'b1; num0 = 16'd0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (done0 === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = i;
            end
            if (busy0 !== 1'b0) n_busy++;
        end
        n_total++;
        if (n_done != 1 || first_done < 1 || first_done > 2)
            $display("FAIL zero_done got %0d pulses at %0d want 1 at <=2",
                     n_done, first_done);
        else n_pass++;
        n_total++;
        if (n_busy != 0)
            $display("FAIL zero_busy got %0d busy cycles want 0", n_busy);
        else n_pass++;
        n_total++;
        if (pat0 !== 4'h8)
            $display("FAIL zero_pat got %h want 8", pat0);
        else n_pass++;
        n_total++;
        if ({mis0, fidx0, fvec0, sg0, sr0} !== 29'h0)
            $display("FAIL zero_status got %h want 0",
                     {mis0, fidx0, fvec0, sg0, sr0});
        else n_pass++;
    endtask

    task automatic test_lat2_period;
        int bad;
        bad = 0;
        @(negedge clk);
        start2 = 1'b1; num2 = 16'd15;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 5) begin
                start2 = 1'b1; num2 = 16'd3;
            end
            if (i == 6) start2 = 1'b0;
            if (pat2 !== SEQ[i] || busy2 !== 1'b1) begin
                bad++;
                $display("FAIL lat2_pat%0d got %h want %h", i, pat2, SEQ[i]);
            end
        end
        n_total++;
        if (bad == 0) n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_total++;
            if (busy2 !== 1'b1 || done2 !== 1'b0 || pat2 !== 4'h9)
                $display("FAIL lat2_drain%0d got b%b d%b p%h want b1 d0 p9",
                         i, busy2, done2, pat2);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if (done2 !== 1'b1 || busy2 !== 1'b0)
            $display("FAIL lat2_done got d%b b%b want d1 b0", done2, busy2);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done2 !== 1'b0 || busy2 !== 1'b0)
            $display("FAIL lat2_idle got d%b b%b want d0 b0", done2, busy2);
        else n_pass++;
        n_total++;
        if (mis2 !== 1'b0 || sg2 !== 4'h9 || sr2 !== 4'h9)
            $display("FAIL lat2_sig got m%b g%h r%h want m0 g9 r9",
                     mis2, sg2, sr2);
        else n_pass++;
    endtask

    task automatic test_reset_midrun;
        int seen;
        seen = 0;
        @(negedge clk);
        start0 = 1'b1; num0 = 16'd5;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (pat0 !== 4'h4)
            $display("FAIL mid_pre_pat got %h want 4", pat0);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({pat0, busy0, done0, mis0, sg0, sr0} !== 15'h0)
            $display("FAIL mid_rst got %h want 0",
                     {pat0, busy0, done0, mis0, sg0, sr0});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done0 !== 1'b0) seen++;
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (done0 !== 1'b0) seen++;
        end
        n_total++;
        if (seen != 0)
            $display("FAIL mid_no_done got %0d done cycles want 0", seen);
        else n_pass++;
        start0 = 1'b1; num0 = 16'd2;
        @(negedge clk);
        start0 = 1'b0;
        n_total++;
        if (pat0 !== 4'h1 || busy0 !== 1'b1)
            $display("FAIL mid_restart got p%h b%b want p1 b1", pat0, busy0);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) seen = 1;
        end
        n_total++;
        if (seen != 1 || sg0 !== 4'h0)
            $display("FAIL mid_finish got done%0d sig%h want done1 sig0",
                     seen, sg0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_inject();
        test_stop_on_fail();
        test_zero_count();
        test_lat2_period();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
